// File: rtl/bit_serial_subtractor_ctrl.sv
// bit_serial_subtractor_ctrl: LSB-first bit-serial a - b - bin over WIDTH bits using one full subtractor
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   start, a, b, bin  : request and operands, captured only when accepted in IDLE
//   busy, done        : busy in RUN/DONE, done is a one-cycle result-valid pulse
//   diff, bout        : registered result and final borrow, held until the next completion
//   zero, ovf         : result flags, present only when SUB_FLAGS_EN is defined
module bit_serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_state_nx;
  logic [WIDTH-1:0] r_a, r_b, r_work, r_diff, w_work_nx;
  logic [CW-1:0] r_cnt;
  logic r_borrow, r_bout, w_d, w_bo, w_last;
  logic [WIDTH:0] w_cat;
  assign w_d = r_a[0] ^ r_b[0] ^ r_borrow;
  assign w_bo = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);
  // new diff bit enters at the MSB so the LSB-first result ends up aligned after WIDTH shifts
  assign w_cat = {w_d, r_work};
  assign w_work_nx = w_cat[WIDTH:1];
  assign w_last = r_cnt == CW'(WIDTH - 1);
  always_comb begin
    w_state_nx = r_state == IDLE ? (start ? RUN : IDLE) :
                 r_state == RUN  ? (w_last ? DONE : RUN) : IDLE;
  end
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign diff = r_diff;
  assign bout = r_bout;
`ifdef SUB_FLAGS_EN
  logic r_a_msb, r_b_msb, r_zero, r_ovf;
  assign zero = r_zero;
  assign ovf = r_ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_zero <= 1'b0;
      r_ovf <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (r_state == RUN && w_last) begin
      r_zero <= w_work_nx == '0;
      r_ovf <= (r_a_msb != r_b_msb) && (w_work_nx[WIDTH-1] != r_a_msb);
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_work <= '0;
      r_cnt <= '0;
      r_borrow <= 1'b0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == IDLE && start) begin
        r_a <= a;
        r_b <= b;
        r_borrow <= bin;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_a <= r_a >> 1;
        r_b <= r_b >> 1;
        r_work <= w_work_nx;
        r_borrow <= w_bo;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_diff <= w_work_nx;
          r_bout <= w_bo;
        end
      end
    end
  end
endmodule
